serial_add_ctrl: RTL

- Bit-serial multi-bit adder controller built around the existing 1-bit full adder (full_adder_str), instantiated once inside this block.
- Accepts WIDTH-bit operands on a start pulse and feeds the full adder one bit per clock, LSB first.
- Holds the carry in a flip-flop and shifts sum bits into a result register.
- Signals completion with a one-cycle done pulse; sits between the operand source and any consumer of the sum.

---
 rtl/full_adder_str.sv | 22 ++
 rtl/serial_add_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/full_adder_str.sv
// 1-bit full adder in structural gate form; the arithmetic primitive
// used bit-serially by serial_add_ctrl.
module full_adder_str (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ab_x;
    logic ab_a;
    logic c_a;

    // Half-adder stage on a/b, second half-adder stage with cin, carry OR.
    assign ab_x = a ^ b;
    assign ab_a = a & b;
    assign c_a  = ab_x & cin;
    assign sum  = ab_x ^ cin;
    assign cout = ab_a | c_a;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller: captures operands on start, feeds
// one bit pair per clock (LSB first) through a single full adder, and
// reports {cout,sum} = a+b+cin with a one-cycle done pulse.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement
// overflow output (ovf).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned SH_W  = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SH_W-1:0]    s_sh_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q;
`endif

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   s_sh_d;
    logic               last_bit;

    // Single shared full adder working on the current LSB pair and carry.
    full_adder_str u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // The shift register only keeps the WIDTH-1 bits already produced; the
    // incoming bit completes the word on the final RUN edge.
    assign s_sh_d   = {fa_sum, s_sh_q};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Controller FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_sh_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= fa_cout;
                    s_sh_q  <= s_sh_d[WIDTH-1:1];
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q is the carry into the MSB on this edge.
                        ovf_q   <= carry_q ^ fa_cout;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
